// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter/sequencer sharing one uart_tx between
// NREQ byte-stream requesters. A grant is held until the owner's last byte
// has been handed to uart_tx, so messages never interleave on the line.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   TO_CYCLES lock-watchdog limit in clk cycles (optional feature only)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/data/last  per-requester byte offer (data in [8*i+7:8*i])
//   req_ack              one-cycle pulse: byte of requester i was taken
//   tx_start, tx_data    start pulse and byte to uart_tx
//   tx_ready             uart_tx idle/ready
//   grant                one-hot transmitter owner, zero when free
//   busy                 high whenever the sequencer is not idle
//   to_err               lock-watchdog timeout pulse
//
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the lock watchdog;
// without it to_err is tied 0 and a locked owner may stall indefinitely.
module uart_tx_arb #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 1200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              to_err
);

  localparam int          IDW = $clog2(NREQ);
  localparam int unsigned NR  = NREQ;

  if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, LOCKED} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n, ack_n;
  logic            start_n;
  logic [7:0]      data_n;
  logic            lock, lock_n;
  logic [IDW-1:0]  last_id, last_id_n;

  logic            scan_hit;
  logic [IDW-1:0]  scan_id, scan_idx;
  logic            do_send;
  logic [IDW-1:0]  send_id;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES);
  logic [CW-1:0] cnt, cnt_n;
  logic          to_err_n;
`endif

  // First valid requester scanning upward from last_id+1, wrapping.
  always_comb begin
    scan_hit = 1'b0;
    scan_id  = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      scan_idx = IDW'((32'(last_id) + k) % NR);
      if (!scan_hit && req_valid[scan_idx]) begin
        scan_hit = 1'b1;
        scan_id  = scan_idx;
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    ack_n     = '0;
    start_n   = 1'b0;
    data_n    = tx_data;
    lock_n    = lock;
    last_id_n = last_id;
    do_send   = 1'b0;
    send_id   = last_id;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_n     = '0;
    to_err_n  = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (tx_ready && scan_hit) begin
          do_send = 1'b1;
          send_id = scan_id;
        end
      end
      // req_valid deliberately ignored: the owner may still hold valid in its ack cycle.
      WAIT_LO: begin
        if (!tx_ready) state_n = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_ready) begin
          if (lock) begin
            state_n = LOCKED;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end
      end
      LOCKED: begin
        if (req_valid[last_id] && tx_ready) do_send = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        if (!req_valid[last_id]) begin
          if (cnt == CW'(TO_CYCLES - 1)) begin
            to_err_n = 1'b1;
            lock_n   = 1'b0;
            grant_n  = '0;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
`endif
      end
      default: state_n = IDLE;
    endcase

    // Shared send path for fresh arbitration and continuation of a locked message.
    if (do_send) begin
      for (int unsigned i = 0; i < NR; i++) begin
        grant_n[i] = (send_id == IDW'(i));
        if (send_id == IDW'(i)) begin
          ack_n[i] = 1'b1;
          data_n   = req_data[8*i +: 8];
          lock_n   = ~req_last[i];
        end
      end
      start_n   = 1'b1;
      last_id_n = send_id;
      state_n   = WAIT_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      lock     <= 1'b0;
      last_id  <= IDW'(NREQ - 1);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      req_ack  <= ack_n;
      tx_start <= start_n;
      tx_data  <= data_n;
      lock     <= lock_n;
      last_id  <= last_id_n;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      to_err <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      to_err <= to_err_n;
    end
  end
`else
  assign to_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios followed by random
// messages, checked against a message-level round-robin model and a simple
// uart_tx ready model.
module tb_uart_tx_arb;

  localparam int NREQ  = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b1;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              to_err;

  uart_tx_arb #(.NREQ(NREQ), .TO_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy),
    .to_err    (to_err)
  );

  always #5 clk = ~clk;

  // Requester queues: {last, data}
  logic [8:0]  mem [NREQ][DEPTH];
  int unsigned head [NREQ];
  int unsigned tail [NREQ];
  bit          pres [NREQ];
  bit          mid  [NREQ];
  int          owner;
  int          m_last;
  logic [7:0]  m_data;
  logic [7:0]  line_log [$];
  logic [NREQ-1:0] prev_valid = '0;

  bit          rand_mode = 1'b0;
  bit          uart_hold = 1'b0;
  int unsigned busy_len = 3;
  int unsigned ubusy = 0;
  int unsigned cyc = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem[i][tail[i] % DEPTH] = {l, d};
    tail[i]++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = tail[i];
      pres[i] = 1'b0;
      mid[i]  = 1'b0;
    end
    owner  = -1;
    m_last = NREQ - 1;
    m_data = 8'h00;
    line_log.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (!pres[i] && head[i] != tail[i])
        if (mid[i] || !rand_mode || $urandom_range(1) == 0) pres[i] = 1'b1;
      req_valid[i] = pres[i];
      if (pres[i]) begin
        req_data[8*i +: 8] = mem[i][head[i] % DEPTH][7:0];
        req_last[i]        = mem[i][head[i] % DEPTH][8];
      end else begin
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom_range(1));
      end
    end
  endtask

  task automatic sb_step();
    int          ai;
    int          win;
    int          j;
    logic [8:0]  ent;
    check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
    check("ack_in_grant", 32'(req_ack & ~grant), 32'd0);
    check("ack_needs_valid", 32'(req_ack & ~prev_valid), 32'd0);
    check("start_eq_ack", 32'(tx_start), 32'(|req_ack));
    check("busy_vs_grant", 32'(busy), 32'(|grant));
`ifndef UART_ARB_TIMEOUT_EN
    check("to_err_zero", 32'(to_err), 32'd0);
`endif
    if (to_err === 1'b1) begin
      if (owner >= 0) mid[owner] = 1'b0;
      owner = -1;
    end
    if (tx_start === 1'b1) begin
      ai = NREQ;
      for (int i = NREQ - 1; i >= 0; i--) if (req_ack[i] === 1'b1) ai = i;
      if (owner >= 0) begin
        win = owner;
      end else begin
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
          j = (m_last + k) % NREQ;
          if (win < 0 && prev_valid[j]) win = j;
        end
      end
      check("winner", 32'(ai), 32'(win));
      if (ai < NREQ && head[ai] != tail[ai]) begin
        ent = mem[ai][head[ai] % DEPTH];
        check("tx_data", 32'(tx_data), 32'(ent[7:0]));
        head[ai]++;
        pres[ai] = 1'b0;
        mid[ai]  = !ent[8];
        owner    = ent[8] ? -1 : ai;
        m_last   = ai;
        m_data   = ent[7:0];
        line_log.push_back(tx_data);
      end
    end else begin
      check("tx_data_hold", 32'(tx_data), 32'(m_data));
    end
  endtask

  task automatic tick();
    prev_valid = req_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (uart_hold) begin
      tx_ready = 1'b0;
    end else if (tx_start === 1'b1) begin
      tx_ready = 1'b0;
      ubusy    = rand_mode ? $urandom_range(1, 4) : busy_len;
    end else if (!tx_ready) begin
      if (ubusy > 0) ubusy--;
      if (ubusy == 0) tx_ready = 1'b1;
    end
    sb_step();
    drive();
  endtask

  task automatic wait_done(input string tag, input int max);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max && !done; n++) begin
      done = (busy === 1'b0) && tx_ready;
      for (int i = 0; i < NREQ; i++) if (head[i] != tail[i] || pres[i]) done = 1'b0;
      if (!done) tick();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input int n);
    logic [7:0] exp [3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    check({tag, "_len"}, 32'(line_log.size()), 32'(n));
    for (int k = 0; k < n && k < line_log.size(); k++)
      check({tag, "_byte"}, 32'(line_log[k]), 32'(exp[k]));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
    model_reset();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_to_err", 32'(to_err), 32'd0);

    // One-byte message from requester 0, one-cycle latency
    busy_len = 3;
    push(0, 8'h41, 1'b1);
    drive();
    tick();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'h41);
    check("t1_ack", 32'(req_ack), 32'b0001);
    check("t1_grant", 32'(grant), 32'b0001);
    tick();
    check("t1_start_pulse", 32'(tx_start), 32'd0);
    check("t1_ack_pulse", 32'(req_ack), 32'd0);
    wait_done("t1_done", 50);
    check("t1_grant_free", 32'(grant), 32'd0);
    check("t1_busy_free", 32'(busy), 32'd0);

    // Requesters 1 and 3 from reset pointer, then rotation
    model_reset();
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    push(1, 8'h31, 1'b1);
    push(3, 8'h33, 1'b1);
    drive();
    wait_done("t2a_done", 100);
    check_log("t2a", 8'h31, 8'h33, 8'h00, 2);
    line_log.delete();
    push(1, 8'h31, 1'b1);
    push(1, 8'h32, 1'b1);
    push(3, 8'h33, 1'b1);
    drive();
    wait_done("t2b_done", 150);
    check_log("t2b", 8'h31, 8'h33, 8'h32, 3);

    // Two-byte message is not interleaved by a later requester
    line_log.delete();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    drive();
    tick();
    check("t3_first_ack", 32'(req_ack), 32'b0001);
    push(2, 8'h5A, 1'b1);
    drive();
    wait_done("t3_done", 150);
    check_log("t3", 8'h41, 8'h42, 8'h5A, 3);

    // tx_ready held low for 50 cycles
    line_log.delete();
    uart_hold = 1'b1;
    tx_ready  = 1'b0;
    push(3, 8'hC3, 1'b1);
    drive();
    for (int n = 0; n < 50; n++) begin
      tick();
      check("t4_no_start", 32'(tx_start), 32'd0);
      check("t4_no_ack", 32'(req_ack), 32'd0);
    end
    uart_hold = 1'b0;
    tx_ready  = 1'b1;
    tick();
    check("t4_start", 32'(tx_start), 32'd1);
    check("t4_data", 32'(tx_data), 32'hC3);
    check("t4_ack", 32'(req_ack), 32'b1000);
    wait_done("t4_done", 50);

    // Reset in WAIT_HI of a locked message
    line_log.delete();
    busy_len = 5;
    push(0, 8'h78, 1'b0);
    push(0, 8'h79, 1'b0);
    push(0, 8'h7A, 1'b1);
    drive();
    tick();
    check("t5_start", 32'(tx_start), 32'd1);
    tick();
    check("t5_busy", 32'(busy), 32'd1);
    model_reset();
    rst = 1'b1;
    drive();
    tick();
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_ack", 32'(req_ack), 32'd0);
    check("t5_rst_start", 32'(tx_start), 32'd0);
    check("t5_rst_data", 32'(tx_data), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_to_err", 32'(to_err), 32'd0);
    rst = 1'b0;
    push(0, 8'h55, 1'b1);
    drive();
    wait_done("t5_done", 100);
    check_log("t5", 8'h55, 8'h00, 8'h00, 1);

    // Owner stalls mid-message
    line_log.delete();
    busy_len = 3;
    push(1, 8'h10, 1'b0);
    push(2, 8'h5A, 1'b1);
    drive();
    tick();
    check("t6_ack", 32'(req_ack), 32'b0010);
    for (int n = 0; n < 20 && !tx_ready; n++) tick();
    check("t6_ready_back", 32'(tx_ready), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO + 1; k++) begin
      tick();
      if (k <= TO) begin
        check("t6_no_err", 32'(to_err), 32'd0);
        check("t6_hold", 32'(grant), 32'b0010);
      end else begin
        check("t6_err", 32'(to_err), 32'd1);
        check("t6_grant_free", 32'(grant), 32'd0);
        check("t6_busy_free", 32'(busy), 32'd0);
      end
    end
    tick();
    check("t6_err_pulse", 32'(to_err), 32'd0);
    check("t6_next_start", 32'(tx_start), 32'd1);
    check("t6_next_data", 32'(tx_data), 32'h5A);
    check("t6_next_ack", 32'(req_ack), 32'b0100);
    wait_done("t6_done", 100);
    check_log("t6", 8'h10, 8'h5A, 8'h00, 2);
`else
    for (int k = 0; k < 40; k++) begin
      tick();
      check("t6_hold", 32'(grant), 32'b0010);
      check("t6_no_start", 32'(tx_start), 32'd0);
    end
    push(1, 8'h11, 1'b1);
    drive();
    wait_done("t6_done", 100);
    check_log("t6", 8'h10, 8'h11, 8'h5A, 3);
`endif

    // Random messages, random requester delays and uart busy times
    rand_mode = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int nmsg;
      nmsg = $urandom_range(1, 6);
      for (int m = 0; m < nmsg; m++) begin
        int ri;
        int len;
        ri  = $urandom_range(0, NREQ - 1);
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) push(ri, 8'($urandom), (b == len - 1) ? 1'b1 : 1'b0);
      end
      drive();
      wait_done("rand_done", 3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
